// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, boots from the reset vector in instruction
// memory, and packs two-word (immediate-carrying) instructions into one FD bundle.
module fetch_unit #(
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned INSTR_WIDTH     = 16,
  parameter int unsigned IMEM_ADDR_WIDTH = 21,
  parameter int unsigned RESET_VEC_ADDR  = 0,
  parameter int unsigned IMM_BIT         = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [PC_WIDTH-1:0]        redirect_pc,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_data,
  output logic [INSTR_WIDTH-1:0]     fd_instr,
  output logic [INSTR_WIDTH-1:0]     fd_imm,
  output logic                       fd_has_imm,
  output logic [PC_WIDTH-1:0]        fd_pc,
  output logic                       fd_valid,
  output logic [PC_WIDTH-1:0]        pc
);

  typedef enum logic [1:0] {StVecHi, StVecLo, StFetch, StImm} state_e;

  localparam logic [IMEM_ADDR_WIDTH-1:0] VecHiAddr = IMEM_ADDR_WIDTH'(RESET_VEC_ADDR);
  localparam logic [IMEM_ADDR_WIDTH-1:0] VecLoAddr = IMEM_ADDR_WIDTH'(RESET_VEC_ADDR + 1);
  localparam logic [PC_WIDTH-1:0]        PcOne     = PC_WIDTH'(1);

  state_e                  state_q;
  logic [PC_WIDTH-1:0]     pc_q;
  logic [INSTR_WIDTH-1:0]  vec_hi_q;
  logic [INSTR_WIDTH-1:0]  hold_instr_q;
  logic [PC_WIDTH-1:0]     hold_pc_q;
  logic [INSTR_WIDTH-1:0]  fd_instr_q;
  logic [INSTR_WIDTH-1:0]  fd_imm_q;
  logic                    fd_has_imm_q;
  logic [PC_WIDTH-1:0]     fd_pc_q;
  logic                    fd_valid_q;

  // Memory read is combinational, so the address must be too.
  always_comb begin
    unique case (state_q)
      StVecHi: imem_addr = VecHiAddr;
      StVecLo: imem_addr = VecLoAddr;
      default: imem_addr = pc_q[IMEM_ADDR_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StVecHi;
      pc_q         <= PC_WIDTH'(RESET_VEC_ADDR);
      vec_hi_q     <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      fd_instr_q   <= '0;
      fd_imm_q     <= '0;
      fd_has_imm_q <= 1'b0;
      fd_pc_q      <= '0;
      fd_valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StVecHi: begin
          vec_hi_q   <= imem_data;
          fd_valid_q <= 1'b0;
          state_q    <= StVecLo;
        end
        StVecLo: begin
          pc_q       <= PC_WIDTH'({vec_hi_q, imem_data});
          fd_valid_q <= 1'b0;
          state_q    <= StFetch;
        end
        StFetch: begin
          if (redirect) begin
            pc_q       <= redirect_pc;
            fd_valid_q <= 1'b0;
          end else if (!stall) begin
            if (imem_data[IMM_BIT]) begin
              // First word of a two-word instruction: park it and emit a bubble.
              hold_instr_q <= imem_data;
              hold_pc_q    <= pc_q;
              fd_valid_q   <= 1'b0;
              state_q      <= StImm;
            end else begin
              fd_instr_q   <= imem_data;
              fd_pc_q      <= pc_q;
              fd_has_imm_q <= 1'b0;
              fd_valid_q   <= 1'b1;
            end
            pc_q <= pc_q + PcOne;
          end
        end
        StImm: begin
          if (redirect) begin
            pc_q       <= redirect_pc;
            fd_valid_q <= 1'b0;
            state_q    <= StFetch;
          end else if (!stall) begin
            fd_instr_q   <= hold_instr_q;
            fd_imm_q     <= imem_data;
            fd_pc_q      <= hold_pc_q;
            fd_has_imm_q <= 1'b1;
            fd_valid_q   <= 1'b1;
            pc_q         <= pc_q + PcOne;
            state_q      <= StFetch;
          end
        end
        default: state_q <= StVecHi;
      endcase
    end
  end

  assign pc         = pc_q;
  assign fd_instr   = fd_instr_q;
  assign fd_imm     = fd_imm_q;
  assign fd_has_imm = fd_has_imm_q;
  assign fd_pc      = fd_pc_q;
  assign fd_valid   = fd_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset vector, straight-line fetch, stall, immediate
// bundling, redirect-over-stall in the immediate state, and PC wrap with mid-IMM reset.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [20:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] fd_instr;
  logic [15:0] fd_imm;
  logic        fd_has_imm;
  logic [31:0] fd_pc;
  logic        fd_valid;
  logic [31:0] pc;

  // Small memory model: words 0..254 map directly, entry 255 stands in for 0x1FFFFF.
  logic [15:0] mem [0:255];

  int unsigned n_checks;
  int unsigned n_pass;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .fd_instr   (fd_instr),
    .fd_imm     (fd_imm),
    .fd_has_imm (fd_has_imm),
    .fd_pc      (fd_pc),
    .fd_valid   (fd_valid),
    .pc         (pc)
  );

  assign imem_data = (imem_addr == 21'h1FFFFF) ? mem[255] :
                     (imem_addr < 21'd255)     ? mem[imem_addr[7:0]] : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge; return at the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset vector and straight-line fetch with a 2-cycle stall.
    clear_mem();
    mem[0]    = 16'h0000;
    mem[1]    = 16'h0010;
    mem[8'h10] = 16'h1000;
    mem[8'h11] = 16'h1001;
    mem[8'h12] = 16'h1002;
    mem[8'h13] = 16'h1003;
    @(negedge clk);
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, fd_valid}, 32'h0);
    check("rst_instr", {16'b0, fd_instr}, 32'h0);
    check("rst_addr", {11'b0, imem_addr}, 32'h0);
    step();
    check("veclo_addr", {11'b0, imem_addr}, 32'h1);
    check("veclo_valid", {31'b0, fd_valid}, 32'h0);
    step();
    check("boot_pc", pc, 32'h10);
    check("boot_valid", {31'b0, fd_valid}, 32'h0);
    step();
    check("sl0_instr", {16'b0, fd_instr}, 32'h1000);
    check("sl0_pc", fd_pc, 32'h10);
    check("sl0_valid", {31'b0, fd_valid}, 32'h1);
    step();
    check("sl1_instr", {16'b0, fd_instr}, 32'h1001);
    check("sl1_pc", fd_pc, 32'h11);
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("stall_instr", {16'b0, fd_instr}, 32'h1001);
      check("stall_fdpc", fd_pc, 32'h11);
      check("stall_pc", pc, 32'h12);
    end
    stall = 1'b0;
    step();
    check("resume_instr", {16'b0, fd_instr}, 32'h1002);
    check("resume_fdpc", fd_pc, 32'h12);
    check("resume_pc", pc, 32'h13);

    // Immediate bundling, then redirect+stall while an immediate is pending.
    clear_mem();
    mem[1]     = 16'h0010;
    mem[8'h10] = 16'h0800;
    mem[8'h11] = 16'hBEEF;
    mem[8'h12] = 16'h0801;
    mem[8'h13] = 16'h1111;
    mem[8'h40] = 16'h2040;
    do_reset();
    step();
    step();
    step();
    check("imm_bubble", {31'b0, fd_valid}, 32'h0);
    check("imm_bubble_pc", pc, 32'h11);
    step();
    check("imm_instr", {16'b0, fd_instr}, 32'h0800);
    check("imm_imm", {16'b0, fd_imm}, 32'hBEEF);
    check("imm_has", {31'b0, fd_has_imm}, 32'h1);
    check("imm_fdpc", fd_pc, 32'h10);
    check("imm_valid", {31'b0, fd_valid}, 32'h1);
    check("imm_pc", pc, 32'h12);
    step();
    check("imm2_bubble", {31'b0, fd_valid}, 32'h0);
    redirect    = 1'b1;
    stall       = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    check("redir_valid", {31'b0, fd_valid}, 32'h0);
    check("redir_pc", pc, 32'h40);
    check("redir_addr", {11'b0, imem_addr}, 32'h40);
    step();
    check("redir_instr", {16'b0, fd_instr}, 32'h2040);
    check("redir_fdpc", fd_pc, 32'h40);
    check("redir_has", {31'b0, fd_has_imm}, 32'h0);
    check("redir_imm_hold", {16'b0, fd_imm}, 32'hBEEF);
    check("redir_valid1", {31'b0, fd_valid}, 32'h1);

    // PC wrap, then reset while in the immediate state.
    clear_mem();
    mem[0]   = 16'hFFFF;
    mem[1]   = 16'hFFFF;
    mem[255] = 16'h1234;
    do_reset();
    step();
    step();
    check("wrap_boot_pc", pc, 32'hFFFF_FFFF);
    check("wrap_boot_addr", {11'b0, imem_addr}, 32'h1F_FFFF);
    step();
    check("wrap_fdpc", fd_pc, 32'hFFFF_FFFF);
    check("wrap_instr", {16'b0, fd_instr}, 32'h1234);
    check("wrap_pc", pc, 32'h0);
    check("wrap_addr", {11'b0, imem_addr}, 32'h0);
    step();
    // mem[0]=0xFFFF has the immediate bit set, so the unit is now in IMM.
    check("wrap_imm_bubble", {31'b0, fd_valid}, 32'h0);
    check("wrap_imm_pc", pc, 32'h1);
    do_reset();
    check("midimm_valid", {31'b0, fd_valid}, 32'h0);
    check("midimm_pc", pc, 32'h0);
    check("midimm_addr", {11'b0, imem_addr}, 32'h0);
    check("midimm_fdpc", fd_pc, 32'h0);
    step();
    check("midimm_veclo", {11'b0, imem_addr}, 32'h1);
    step();
    check("midimm_reboot", pc, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
